neg_arbiter: RTL

NEG_ARBITER -- requirements
Module: neg_arbiter

---
 rtl/neg_arbiter_pkg.sv | 16 +
 rtl/neg_arbiter_if.sv | 38 +++
 rtl/neg_core.sv | 11 +
 rtl/neg_arbiter.sv | 84 ++++++++
 4 files changed

// File: rtl/neg_arbiter_pkg.sv
// Shared constants for the round-robin negation arbiter: default sizes,
// FSM state encodings and the most-negative operand helper.
package neg_arbiter_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 4;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    // Bit pattern 1 followed by width-1 zeros; callers truncate to their width.
    function automatic logic [31:0] most_neg(input int width);
        return 32'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/neg_arbiter_if.sv
// Requester/result bus of neg_arbiter. out_ovf exists only when
// NEG_ARBITER_OVF_EN is defined.
interface neg_arbiter_if
    import neg_arbiter_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [IW-1:0]         out_id;
    logic                  out_ready;
`ifdef NEG_ARBITER_OVF_EN
    logic                  out_ovf;
`endif

    modport master (
        output req_valid, req_data, out_ready,
`ifdef NEG_ARBITER_OVF_EN
        input  out_ovf,
`endif
        input  req_ready, out_valid, out_data, out_id
    );

    modport slave (
        input  req_valid, req_data, out_ready,
`ifdef NEG_ARBITER_OVF_EN
        output out_ovf,
`endif
        output req_ready, out_valid, out_data, out_id
    );

endinterface

// File: rtl/neg_core.sv
// Combinational two's-complement negation: result = ~operand + 1, truncated.
module neg_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]        operand,
    output logic signed [WIDTH-1:0] result
);

    assign result = $signed(~operand + 1'b1);

endmodule

// File: rtl/neg_arbiter.sv
// Round-robin arbiter feeding one shared negation unit into a single result
// register (EMPTY/FULL). Optional NEG_ARBITER_OVF_EN adds out_ovf.
module neg_arbiter
    import neg_arbiter_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    neg_arbiter_if.slave bus
);

    localparam int IW = $clog2(NREQ);
    localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_neg(WIDTH));

    logic [0:0]              state;
    logic [IW-1:0]           ptr;
    logic [IW-1:0]           gnt_idx;
    logic [IW:0]             cand;
    logic                    gnt_found;
    logic                    accept;
    logic                    fire;
    logic [WIDTH-1:0]        operand;
    logic signed [WIDTH-1:0] neg_val;

    // Search from ptr upward with wrap; first valid requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ))
                cand = cand - (IW+1)'(NREQ);
            if (!gnt_found && bus.req_valid[cand[IW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IW-1:0];
            end
        end
    end

    // Reset gates the grant so no operand is consumed while rst_n is low.
    assign accept = rst_n && ((state == ST_EMPTY) || bus.out_ready);
    assign fire   = accept && gnt_found;

    always_comb begin
        bus.req_ready = '0;
        if (fire)
            bus.req_ready[gnt_idx] = 1'b1;
    end

    assign operand = bus.req_data[int'(gnt_idx)*WIDTH +: WIDTH];

    neg_core #(.WIDTH(WIDTH)) u_neg (
        .operand (operand),
        .result  (neg_val)
    );

    assign bus.out_valid = (state == ST_FULL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_EMPTY;
            ptr          <= '0;
            bus.out_data <= '0;
            bus.out_id   <= '0;
`ifdef NEG_ARBITER_OVF_EN
            bus.out_ovf  <= 1'b0;
`endif
        end else if (fire) begin
            state        <= ST_FULL;
            bus.out_data <= neg_val;
            bus.out_id   <= gnt_idx;
            ptr          <= (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
`ifdef NEG_ARBITER_OVF_EN
            bus.out_ovf  <= (operand == MOST_NEG);
`endif
        end else if (state == ST_FULL && bus.out_ready) begin
            state <= ST_EMPTY;
        end
    end

endmodule
